wide_add_sequencer: RTL and testbench

Multi-word add sequencer that sits directly upstream of the 32-bit carry-select adder (CSA) and consumes its result. It accepts wide operands over a valid/ready handshake and feeds the CSA one word per cycle, least-significant word first, chaining the carry between words. It assembles the wide sum, the final carry-out and the signed overflow flag, then presents them downstream over a valid/ready handshake.

---
 rtl/adder_pkg.sv | 17 +
 rtl/wide_add_sequencer.sv | 118 +++++++++++
 tb/tb_wide_add_sequencer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared types and constants for the multi-word add sequencer and its CSA.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ADD_W = 32;

  // Width of a word index; never below one bit so it stays a legal vector.
  function automatic int idx_w(input int nwords);
    return (nwords > 1) ? $clog2(nwords) : 1;
  endfunction

endpackage

// File: rtl/wide_add_sequencer.sv
// Feeds wide operands through an external 32-bit CSA one word per cycle,
// LSW first, chaining the carry, and returns sum/carry/overflow downstream.
module wide_add_sequencer
  import adder_pkg::*;
#(
  parameter int W      = ADD_W,
  parameter int NWORDS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W*NWORDS-1:0] in_a,
  input  logic [W*NWORDS-1:0] in_b,
  input  logic                in_cin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W*NWORDS-1:0] out_sum,
  output logic                out_cout,
  output logic                out_of,
  output logic [W-1:0]        add_a,
  output logic [W-1:0]        add_b,
  output logic                add_cin,
  input  logic [W-1:0]        add_sum,
  input  logic                add_cout,
  input  logic                add_of
);

  localparam int             IW   = idx_w(NWORDS);
  localparam int             TW   = W * NWORDS;
  localparam logic [IW-1:0]  LAST = IW'(NWORDS - 1);

  // Both sides are valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high; valid and its payload hold until then.

  state_t          state;
  logic [TW-1:0]   a_reg;
  logic [TW-1:0]   b_reg;
  logic [TW-1:0]   acc_reg;
  logic [TW-1:0]   sum_reg;
  logic            carry_reg;
  logic            cout_reg;
  logic            of_reg;
  logic [IW-1:0]   idx;

  logic [W-1:0]    word_a;
  logic [W-1:0]    word_b;
  logic [TW-1:0]   acc_next;

  // acc_reg collects the partial sum so the visible out_sum only changes
  // when a whole operation has completed.
  always_comb begin
    word_a   = '0;
    word_b   = '0;
    acc_next = acc_reg;
    for (int i = 0; i < NWORDS; i++) begin
      if (idx == IW'(i)) begin
        word_a              = a_reg[i*W +: W];
        word_b              = b_reg[i*W +: W];
        acc_next[i*W +: W]  = add_sum;
      end
    end
  end

  assign add_a     = (state == RUN) ? word_a : '0;
  assign add_b     = (state == RUN) ? word_b : '0;
  assign add_cin   = (state == RUN) ? carry_reg : 1'b0;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_sum   = sum_reg;
  assign out_cout  = cout_reg;
  assign out_of    = of_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      of_reg    <= 1'b0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= in_a;
            b_reg     <= in_b;
            carry_reg <= in_cin;
            idx       <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          acc_reg   <= acc_next;
          carry_reg <= add_cout;
          if (idx == LAST) begin
            // Only the top word's overflow describes the full-width add.
            sum_reg  <= acc_next;
            cout_reg <= add_cout;
            of_reg   <= add_of;
            idx      <= '0;
            state    <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Bench for wide_add_sequencer: behavioural CSA, wide-add reference model,
// per-cycle result scoreboard, directed corner cases and random traffic.
module tb_wide_add_sequencer;

  localparam int W      = 32;
  localparam int NWORDS = 2;
  localparam int TW     = W * NWORDS;

  typedef logic [TW+1:0] res_t;  // {cout, of, sum}

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid, in_ready, in_cin;
  logic [TW-1:0] in_a, in_b;
  logic          out_valid, out_ready, out_cout, out_of;
  logic [TW-1:0] out_sum;
  logic [W-1:0]  add_a, add_b, add_sum;
  logic          add_cin, add_cout, add_of;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // Behavioural stand-in for the combinational 32-bit CSA.
  logic [W:0] csa_full;
  assign csa_full = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
  assign add_sum  = csa_full[W-1:0];
  assign add_cout = csa_full[W];
  assign add_of   = (add_a[W-1] == add_b[W-1]) && (add_sum[W-1] != add_a[W-1]);

  wide_add_sequencer #(.W(W), .NWORDS(NWORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_of(out_of),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout), .add_of(add_of)
  );

  // ---------------- model and scoreboard ----------------
  res_t exp_q[$];
  int   n_vec = 0;
  int   n_fail = 0;
  int   accept_cyc = 0;

  function automatic res_t model(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                 input logic cin);
    logic [TW:0] s;
    logic        of;
    s  = {1'b0, a} + {1'b0, b} + {{TW{1'b0}}, cin};
    of = (a[TW-1] == b[TW-1]) && (s[TW-1] != a[TW-1]);
    return {s[TW], of, s[TW-1:0]};
  endfunction

  task automatic check(input string name, input res_t act, input res_t exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: got timeout required event", name);
  endtask

  // Result compare on every falling edge where outputs are meaningful.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        check("busy_in_ready", res_t'(in_ready), res_t'(0));
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_result: got %h required none",
                   {out_cout, out_of, out_sum});
        end else begin
          check("result", {out_cout, out_of, out_sum}, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end else if (in_ready) begin
        check("idle_add_zero", res_t'({add_cin, add_b, add_a}), res_t'(0));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic cin);
    logic ok;
    ok       = 1'b0;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      fail_now("accept_timeout");
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      exp_q.push_back(model(a, b, cin));
      accept_cyc = cyc;
      in_valid   = 1'b0;
    end
  endtask

  // Counts falling edges from acceptance until out_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int t = 1; t <= 50; t++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = t;
        break;
      end
    end
    if (lat == 0) fail_now("valid_timeout");
  endtask

  task automatic run_directed(input string name, input logic [TW-1:0] a,
                              input logic [TW-1:0] b, input logic cin, input res_t lit);
    int lat;
    send(a, b, cin);
    wait_valid(lat);
    check(name, {out_cout, out_of, out_sum}, lit);
    check("latency", res_t'(lat), res_t'(NWORDS + 1));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rand_word();
    case ($urandom_range(0, 4))
      0:       return 32'h0000_0000;
      1:       return 32'hffff_ffff;
      2:       return 32'h7fff_ffff;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  logic          rand_done;
  logic [TW-1:0] a6, b6;
  logic [W:0]    low6;
  int            c1, lat;

  initial begin
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b1;
    rand_done = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("rst_in_ready", res_t'(in_ready), res_t'(1));
    check("rst_out_valid", res_t'(out_valid), res_t'(0));
    check("rst_outputs", {out_cout, out_of, out_sum}, res_t'(0));
    check("rst_add", res_t'({add_cin, add_b, add_a}), res_t'(0));

    run_directed("low_of_ignored", 64'h00000000_7fffffff, 64'h00000000_7fffffff, 1'b0,
                 {2'b00, 64'h00000000_fffffffe});
    run_directed("carry_chain_of", 64'h7fffffff_ffffffff, 64'h00000000_00000001, 1'b0,
                 {2'b01, 64'h80000000_00000000});
    run_directed("neg_plus_neg", 64'hffffffff_ffffffff, 64'hffffffff_ffffffff, 1'b0,
                 {2'b10, 64'hffffffff_fffffffe});
    run_directed("cin_wrap", 64'h0, 64'hffffffff_ffffffff, 1'b1,
                 {2'b10, 64'h0});

    // Back-to-back throughput with out_ready held high.
    send(64'h1, 64'h2, 1'b0);
    c1 = accept_cyc;
    send(64'h00000005_00000000, 64'h3, 1'b1);
    check("throughput", res_t'(accept_cyc - c1), res_t'(NWORDS + 2));
    wait_valid(lat);
    @(posedge clk);
    #1;

    // Backpressure: result held, second operand waits for the IDLE cycle.
    out_ready = 1'b0;
    send(64'h12345678_9abcdef0, 64'h11111111_11111111, 1'b0);
    in_a     = 64'h80000000_00000000;
    in_b     = 64'h80000000_00000000;
    in_cin   = 1'b1;
    in_valid = 1'b1;
    wait_valid(lat);
    repeat (5) begin
      @(negedge clk);
      check("hold_in_ready", res_t'(in_ready), res_t'(0));
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("idle_after_hs", res_t'({in_ready, out_valid}), res_t'(2'b10));
    @(posedge clk);
    #1;
    exp_q.push_back(model(64'h80000000_00000000, 64'h80000000_00000000, 1'b1));
    in_valid = 1'b0;
    check("second_taken", res_t'(in_ready), res_t'(0));
    wait_valid(lat);
    check("second_latency", res_t'(lat), res_t'(NWORDS + 1));
    check("second_lit", {out_cout, out_of, out_sum}, {2'b11, 64'h1});
    @(posedge clk);
    #1;

    // Reset in the middle of RUN while the top word is on the CSA.
    a6   = 64'h00000001_ffffffff;
    b6   = 64'h00000000_00000001;
    low6 = {1'b0, a6[W-1:0]} + {1'b0, b6[W-1:0]};
    send(a6, b6, 1'b0);
    @(posedge clk);
    #1;
    check("mid_add_word1", res_t'({add_cin, add_b, add_a}),
          res_t'({low6[W], b6[TW-1:W], a6[TW-1:W]}));
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("abort_out_valid", res_t'(out_valid), res_t'(0));
    check("abort_outputs", {out_cout, out_of, out_sum}, res_t'(0));
    check("abort_add", res_t'({add_cin, add_b, add_a}), res_t'(0));
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("release_in_ready", res_t'(in_ready), res_t'(1));
    repeat (6) begin
      @(negedge clk);
      check("no_ghost_valid", res_t'(out_valid), res_t'(0));
    end
    @(posedge clk);
    #1;

    // Random operands with random backpressure.
    fork
      begin
        for (int n = 0; n < 60; n++) begin
          send({rand_word(), rand_word()}, {rand_word(), rand_word()},
               1'($urandom_range(0, 1)));
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #2 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join

    out_ready = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) break;
    end
    check("drain", res_t'(exp_q.size()), res_t'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
